// File: rtl/nand_nor_sweeper_pkg.sv
// gate_sweep_pkg: shared definitions for the reduction-gate sweeper.
//   mode_e     : gate function select (NAND/NOR/AND/OR)
//   state_e    : 2-bit sweeper FSM state encoding
//   expected() : reference output of an n-input reduction gate
package gate_sweep_pkg;

  localparam int unsigned MAX_N = 8;

  typedef enum logic [1:0] {
    MODE_NAND = 2'b00,
    MODE_NOR  = 2'b01,
    MODE_AND  = 2'b10,
    MODE_OR   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_CHECK = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Only the low n bits of v take part; the rest are ignored so AND/NAND
  // are not polluted by zero padding.
  function automatic logic expected(input logic [1:0] mode,
                                    input logic [MAX_N-1:0] v,
                                    input int unsigned n);
    logic all_one;
    logic any_one;
    all_one = 1'b1;
    any_one = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        all_one = all_one & v[i];
        any_one = any_one | v[i];
      end
    end
    case (mode)
      MODE_NAND: expected = ~all_one;
      MODE_NOR:  expected = ~any_one;
      MODE_AND:  expected = all_one;
      default:   expected = any_one;
    endcase
  endfunction

endpackage

// File: rtl/nand_nor_sweeper_gate_model.sv
// gate_model: combinational N-input reduction gate reference.
//   mode : 00 NAND, 01 NOR, 10 AND, 11 OR
//   v    : gate inputs
//   y    : gate output
module gate_model
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [1:0]   mode,
  input  logic [N-1:0] v,
  output logic         y
);

  logic [MAX_N-1:0] v_ext;

  always_comb begin
    v_ext        = '0;
    v_ext[N-1:0] = v;
    y            = expected(mode, v_ext, N);
  end

endmodule

// File: rtl/nand_nor_sweeper.sv
// nand_nor_sweeper: exhaustive exerciser for an N-input reduction gate.
// On start, drives every vector 0..2^N-1 onto gut_in, holds each for SETTLE
// cycles, then samples gut_y in a CHECK cycle against the reference model.
//   clk, rst          : clock, synchronous active-high reset
//   start, mode       : sweep request and gate function (latched on accept)
//   gut_in, gut_y     : stimulus to / response from the gate under test
//   busy, done        : sweep in progress / one-cycle completion pulse
//   pass              : last completed sweep had no mismatches
//   err_count         : mismatch count of current/last sweep
//   first_fail(_valid): first mismatching vector
module nand_nor_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N      = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  output logic [N-1:0] gut_in,
  input  logic         gut_y,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail,
  output logic         first_fail_valid
);

  localparam logic [N-1:0] LAST_VEC    = '1;
  localparam logic [3:0]   SETTLE_LOAD = 4'(SETTLE - 1);

  state_e       state_q, state_d;
  logic [1:0]   mode_q, mode_d;
  logic [N-1:0] vec_q, vec_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N:0]   err_q, err_d;
  logic [N-1:0] ff_q, ff_d;
  logic         ffv_q, ffv_d;
  logic         pass_q, pass_d;
  logic         exp_y;

  gate_model #(.N(N)) u_ref (
    .mode (mode_q),
    .v    (vec_q),
    .y    (exp_y)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          mode_d  = mode;
          vec_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
          pass_d  = 1'b0;
          cnt_d   = SETTLE_LOAD;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == 4'd0) state_d = ST_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_CHECK: begin
        if (gut_y != exp_y) begin
          err_d = err_q + {{N{1'b0}}, 1'b1};
          if (!ffv_q) begin
            ff_d  = vec_q;
            ffv_d = 1'b1;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + {{(N-1){1'b0}}, 1'b1};
          cnt_d   = SETTLE_LOAD;
          state_d = ST_DRIVE;
        end
      end
      default: begin
        // err_q is final here: the last CHECK updated it on entry to DONE.
        pass_d  = (err_q == '0);
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  assign gut_in           = vec_q;
  assign busy             = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
  assign done             = (state_q == ST_DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_nand_nor_sweeper.sv
// Scoreboard bench for nand_nor_sweeper: two instances (N=3/SETTLE=1 and
// N=4/SETTLE=3). Stimulus pushes expected sweep results; monitors pop and
// compare on every done pulse.
module tb_nand_nor_sweeper;

  localparam int unsigned NA = 3;
  localparam int unsigned SA = 1;
  localparam int unsigned NB = 4;
  localparam int unsigned SB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          start_a, busy_a, done_a, pass_a, ffv_a, gut_y_a;
  logic [1:0]    mode_a;
  logic [NA-1:0] gut_in_a, ff_a;
  logic [NA:0]   err_a;
  logic [1:0]    gold_mode_a;
  logic          gold_y_a, stuck_a;

  logic          start_b, busy_b, done_b, pass_b, ffv_b, gut_y_b;
  logic [1:0]    mode_b;
  logic [NB-1:0] gut_in_b, ff_b;
  logic [NB:0]   err_b;

  gate_model #(.N(NA)) u_gold_a (.mode(gold_mode_a), .v(gut_in_a), .y(gold_y_a));
  gate_model #(.N(NB)) u_gold_b (.mode(2'b11), .v(gut_in_b), .y(gut_y_b));
  assign gut_y_a = stuck_a ? 1'b1 : gold_y_a;

  nand_nor_sweeper #(.N(NA), .SETTLE(SA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
    .gut_in(gut_in_a), .gut_y(gut_y_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_fail(ff_a),
    .first_fail_valid(ffv_a)
  );

  nand_nor_sweeper #(.N(NB), .SETTLE(SB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
    .gut_in(gut_in_b), .gut_y(gut_y_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_fail(ff_b),
    .first_fail_valid(ffv_b)
  );

  typedef struct {
    int unsigned busy_cycles;
    int unsigned err;
    int unsigned ff;
    bit          ffv;
    bit          pass;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor A
  initial begin
    int unsigned busy_cnt = 0;
    bit pend = 0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("a_pass", pass_a, cur.pass);
        pend = 0;
      end
      if (busy_a) busy_cnt++;
      else if (!done_a) busy_cnt = 0;
      if (done_a) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_done", done_a, 0);
        end else begin
          cur = q_a.pop_front();
          check("a_busy_cycles", busy_cnt, cur.busy_cycles);
          check("a_err_count", err_a, cur.err);
          check("a_first_fail_valid", ffv_a, cur.ffv);
          if (cur.ffv) check("a_first_fail", ff_a, cur.ff);
          pend = 1;
        end
        busy_cnt = 0;
      end
    end
  end

  // Monitor B
  initial begin
    int unsigned busy_cnt = 0;
    bit pend = 0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("b_pass", pass_b, cur.pass);
        pend = 0;
      end
      if (busy_b) busy_cnt++;
      else if (!done_b) busy_cnt = 0;
      if (done_b) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_done", done_b, 0);
        end else begin
          cur = q_b.pop_front();
          check("b_busy_cycles", busy_cnt, cur.busy_cycles);
          check("b_err_count", err_b, cur.err);
          check("b_first_fail_valid", ffv_b, cur.ffv);
          if (cur.ffv) check("b_first_fail", ff_b, cur.ff);
          pend = 1;
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic sweep_a(input logic [1:0] m, input exp_t e);
    @(negedge clk);
    mode_a  = m;
    start_a = 1'b1;
    q_a.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    check("a_busy_after_start", busy_a, 1);
    check("a_gut_in_after_start", gut_in_a, 0);
  endtask

  task automatic wait_done_a(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a) return;
    end
    check("a_done_timeout", done_a, 1);
  endtask

  task automatic wait_done_b(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_b) return;
    end
    check("b_done_timeout", done_b, 1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_gut_in"}, gut_in_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_pass"}, pass_a, 0);
    check({tag, "_err_count"}, err_a, 0);
    check({tag, "_first_fail"}, ff_a, 0);
    check({tag, "_first_fail_valid"}, ffv_a, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    start_a = 1'b0; mode_a = 2'b00; stuck_a = 1'b0; gold_mode_a = 2'b00;
    start_b = 1'b0; mode_b = 2'b00;
    repeat (2) @(negedge clk);
    check_reset_a("rst_a");
    check("rst_b_busy", busy_b, 0);
    check("rst_b_err_count", err_b, 0);
    rst = 1'b0;

    // Healthy NAND
    e = '{busy_cycles: 16, err: 0, ff: 0, ffv: 0, pass: 1};
    sweep_a(2'b00, e);
    wait_done_a(40);
    @(negedge clk);

    // Stuck-at-1 output, NAND: only vector 7 fails
    stuck_a = 1'b1;
    e = '{busy_cycles: 16, err: 1, ff: 7, ffv: 1, pass: 0};
    sweep_a(2'b00, e);
    wait_done_a(40);
    @(negedge clk);
    stuck_a = 1'b0;

    // NOR checked against a NAND gate: vectors 1..6 fail
    gold_mode_a = 2'b00;
    e = '{busy_cycles: 16, err: 6, ff: 1, ffv: 1, pass: 0};
    sweep_a(2'b01, e);
    wait_done_a(40);
    @(negedge clk);

    // N=4, SETTLE=3, OR; mode toggled mid-sweep has no effect
    @(negedge clk);
    mode_b  = 2'b11;
    start_b = 1'b1;
    q_b.push_back('{busy_cycles: 64, err: 0, ff: 0, ffv: 0, pass: 1});
    @(negedge clk);
    start_b = 1'b0;
    check("b_busy_after_start", busy_b, 1);
    repeat (10) @(negedge clk);
    mode_b = 2'b00;
    repeat (10) @(negedge clk);
    mode_b = 2'b01;
    wait_done_b(100);
    @(negedge clk);

    // Extra start while busy is ignored
    e = '{busy_cycles: 16, err: 0, ff: 0, ffv: 0, pass: 1};
    sweep_a(2'b00, e);
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    mode_a  = 2'b01;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(40);
    @(negedge clk);

    // Reset mid-sweep (NOR vs NAND gate so errors have accumulated)
    @(negedge clk);
    mode_a  = 2'b01;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_err_nonzero_before_rst", (err_a != 0) ? 1 : 0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_a("abort_a");
    repeat (40) @(negedge clk);
    check("abort_no_sweep_running", busy_a, 0);

    // Clean sweep after reset
    e = '{busy_cycles: 16, err: 0, ff: 0, ffv: 0, pass: 1};
    sweep_a(2'b00, e);
    wait_done_a(40);
    @(negedge clk);

    // Back-to-back: start in DONE ignored, next IDLE start accepted
    stuck_a = 1'b1;
    e = '{busy_cycles: 16, err: 1, ff: 7, ffv: 1, pass: 0};
    sweep_a(2'b00, e);
    wait_done_a(40);
    start_a = 1'b1;
    stuck_a = 1'b0;
    mode_a  = 2'b00;
    @(negedge clk);
    check("a_start_in_done_ignored", busy_a, 0);
    q_a.push_back('{busy_cycles: 16, err: 0, ff: 0, ffv: 0, pass: 1});
    @(negedge clk);
    start_a = 1'b0;
    check("a_b2b_accepted", busy_a, 1);
    check("a_b2b_err_cleared", err_a, 0);
    check("a_b2b_ffv_cleared", ffv_a, 0);
    wait_done_a(40);
    repeat (2) @(negedge clk);

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nand_nor_sweeper.md
# nand_nor_sweeper

Self-checking exhaustive exerciser for an N-input reduction gate (NAND/NOR/AND/OR). On `start` it drives every input pattern from 0 to 2^N−1 onto the gate under test, waits a programmable settle time, and samples the gate output. It compares each sample against a built-in reference and reports a pass flag, an error count and the first failing vector. It sits beside the `nand_three` family of gates and replaces hand-written stimulus lists with a hardware sweep usable in simulation or on a board.

## Interface
- `N`, default 3: gate input width; legal range 2..8.
- `SETTLE`, default 1: cycles each vector is held before the check cycle; legal range 1..15.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begins a sweep; sampled only in IDLE.
- `mode` input 2: 00 NAND, 01 NOR, 10 AND, 11 OR; latched on the accepted `start`.
- `gut_in` output N: vector driven to the gate under test.
- `gut_y` input 1: gate-under-test output.
- `busy` output 1: high in DRIVE and CHECK.
- `done` output 1: one-cycle pulse when a sweep completes.
- `pass` output 1: 1 if the last completed sweep had zero errors; held until the next accepted `start`.
- `err_count` output N+1: number of mismatching vectors in the current or last sweep (max 2^N).
- `first_fail` output N: first mismatching vector.
- `first_fail_valid` output 1: `first_fail` holds a captured value.

## Operation
- One clock; reset is synchronous and active-high. Clock port is `clk`, reset port is `rst`.
- FSM states: IDLE, DRIVE, CHECK, DONE.
  - IDLE to DRIVE on `start`=1. On that edge: latch `mode`; clear `gut_in`, `err_count`, `first_fail`, `first_fail_valid` and `pass`; load the settle counter.
  - DRIVE holds `gut_in` for exactly SETTLE cycles, then moves to CHECK.
  - CHECK samples `gut_y` on its closing edge and compares it with `expected(mode_q, gut_in)`:
    - NAND = ~&v
    - NOR = ~|v
    - AND = &v
    - OR = |v
  - Mismatch in CHECK: `err_count` += 1. If `first_fail_valid`=0, capture `first_fail` = `gut_in` and set `first_fail_valid`.
  - After CHECK: if `gut_in` = 2^N−1, go to DONE; otherwise `gut_in` += 1 and go to DRIVE.
  - DONE lasts one cycle with `done`=1. On exit, `pass` = (`err_count`==0). Then go to IDLE.
- `start` is ignored in DRIVE, CHECK and DONE. `mode` changes after acceptance have no effect.
- `gut_in` never wraps mid-sweep. The sweep ends after vector 2^N−1 is checked.
- `err_count` cannot overflow: its width is N+1 bits and the maximum count is 2^N.
- Reset mid-sweep aborts the sweep with no `done` pulse. All outputs return to their reset values on the next edge.

## Timing
- Reset values: state IDLE, `gut_in`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail`=0, `first_fail_valid`=0.
- `start` accepted at edge k: `busy`=1 and `gut_in`=0 from cycle k+1.
- Each vector occupies SETTLE+1 cycles.
- Total `busy` duration is 2^N·(SETTLE+1) cycles.
- `done` is high in the cycle right after the last CHECK.
- `pass` is valid from the cycle after `done`.
- `err_count` and `first_fail` update on the closing edge of CHECK, so they are visible in the following cycle.
- Asserting `start` in the DONE cycle is ignored. A new sweep may start from the first IDLE cycle.

## Structure
- Shared package `gate_sweep_pkg`:
  - mode constants: MODE_NAND, MODE_NOR, MODE_AND, MODE_OR
  - 2-bit state encoding
  - `expected()` reference function
- Sub-module `gate_model` (parameter N): combinational reference with `mode` and `v[N-1:0]` in, `y` out. The sweeper instantiates it for the comparison. Benches reuse it as a golden gate under test.
- Top-level RTL contains only the FSM, settle counter, vector counter and result registers.

## Test plan
- **Healthy NAND, N=3, SETTLE=1:** `gut_y` driven by `gate_model`, `mode`=00, `start` pulse.
  - `busy` high for exactly 16 cycles, `done` one pulse, `pass`=1, `err_count`=0, `first_fail_valid`=0.
- **Stuck-at-1 output:** `gut_y`=1, `mode`=00.
  - Only vector 7 fails: `err_count`=1, `first_fail`=3'b111, `pass`=0.
- **NOR with wrong gate:** `mode`=01, `gut_y` = NAND model.
  - Mismatches on vectors 1..6: `err_count`=6, `first_fail`=3'b001.
- **Parameters and mode latch, N=4, SETTLE=3:** `mode`=11 with an OR model; toggle `mode` mid-sweep.
  - `busy` for 64 cycles, result unaffected, `pass`=1.
- **Start and reset during a sweep:** pulse `start` while busy, then assert `rst` during the sweep.
  - Extra `start` ignored (sweep length unchanged).
  - After reset, all outputs at reset values and no `done` pulse.
  - A new `start` runs a full clean sweep.
- **Back-to-back sweeps:** `start` asserted in the DONE cycle is ignored; the next IDLE `start` is accepted.
  - Second sweep clears the prior `err_count` and `first_fail_valid` on acceptance.
